sprite_buffer_loader: RTL and testbench

//  Fills the packed 1-bit-per-channel sprite buffers (BUFFER_R/G/B) that the sprite

---
 rtl/sprite_pkg.sv | 34 +++
 rtl/rom_latency_pipe.sv | 42 ++++
 rtl/sprite_buffer_loader.sv | 242 ++++++++++++++++++++++++
 tb/tb_sprite_buffer_loader.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite buffer loader.
//   DEF_*          default geometry used by sprite_buffer_loader parameters
//   DIM_W / N_W    width of one sprite dimension / of the W*H pixel count
//   R/G/B_BIT      channel positions inside the 3-bit ROM pixel word
//   state_e        loader FSM states
//   pixel_count()  full-width W*H product used by the size check
package sprite_pkg;

  localparam int unsigned DEF_MAX_PIXELS  = 400;
  localparam int unsigned DEF_ADDR_W      = 12;
  localparam int unsigned DEF_ROM_LATENCY = 1;

  localparam int unsigned DIM_W = 10;
  localparam int unsigned N_W   = 2 * DIM_W;

  localparam int unsigned R_BIT = 2;
  localparam int unsigned G_BIT = 1;
  localparam int unsigned B_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_FETCH,
    ST_DRAIN,
    ST_READY,
    ST_COMMIT
  } state_e;

  function automatic logic [N_W-1:0] pixel_count(input logic [DIM_W-1:0] w,
                                                 input logic [DIM_W-1:0] h);
    return N_W'(w) * N_W'(h);
  endfunction

endpackage

// File: rtl/rom_latency_pipe.sv
// Delay line matching the sprite ROM read latency. Each fetch pushes
// {valid, idx}; the pair emerges LATENCY cycles later, aligned with the
// ROM data for that fetch.
//   clk_i    clock
//   rst_i    synchronous active-high clear
//   valid_i  a ROM read was issued this cycle
//   idx_i    destination pixel index of that read
//   valid_o  ROM data on the bus belongs to a fetch
//   idx_o    destination pixel index for that data
module rom_latency_pipe #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned IDX_W   = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [LATENCY-1:0] vld_q;
  logic [IDX_W-1:0]   idx_q [LATENCY];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= valid_i;
      idx_q[0] <= idx_i;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign valid_o = vld_q[LATENCY-1];
  assign idx_o   = idx_q[LATENCY-1];

endmodule

// File: rtl/sprite_buffer_loader.sv
// Sprite buffer loader: streams W*H pixels from a synchronous sprite ROM
// into a shadow buffer, then commits the shadow to the renderer-facing
// BUFFER_R/G/B planes on FRAME_SYNC so the visible frame never tears.
// Optional feature macro: MIRROR_X_EN (adds MIRROR_X, horizontal flip on load).
//   CLK, reset        clock, synchronous active-high reset
//   START             load request, accepted only in IDLE
//   BASE_ADDR         ROM address of pixel (0,0)
//   LARGURA_OBJETO    sprite width W
//   ALTURA_OBJETO     sprite height H
//   MIRROR_X          (MIRROR_X_EN) flip columns while loading
//   ROM_ADDR/ROM_DATA ROM read port, data ROM_LATENCY cycles after address
//   FRAME_SYNC        vertical-blank pulse, commits a finished load
//   BUFFER_R/G/B      committed planes, bit i = pixel y*W + x
//   BUSY/DONE/ERROR   load in progress / commit pulse / size-reject pulse
module sprite_buffer_loader
  import sprite_pkg::*;
#(
  parameter int unsigned MAX_PIXELS  = DEF_MAX_PIXELS,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned ROM_LATENCY = DEF_ROM_LATENCY
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  START,
  input  logic [ADDR_W-1:0]     BASE_ADDR,
  input  logic [DIM_W-1:0]      LARGURA_OBJETO,
  input  logic [DIM_W-1:0]      ALTURA_OBJETO,
`ifdef MIRROR_X_EN
  input  logic                  MIRROR_X,
`endif
  output logic [ADDR_W-1:0]     ROM_ADDR,
  input  logic [2:0]            ROM_DATA,
  input  logic                  FRAME_SYNC,
  output logic [0:MAX_PIXELS-1] BUFFER_R,
  output logic [0:MAX_PIXELS-1] BUFFER_G,
  output logic [0:MAX_PIXELS-1] BUFFER_B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERROR
);

  localparam int unsigned CNT_W   = $clog2(MAX_PIXELS + 1);
  localparam int unsigned DRAIN_W = 3;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DIM_W-1:0]      w_q, w_d;
  logic [DIM_W-1:0]      h_q, h_d;
  logic [CNT_W-1:0]      n_q, n_d;
  logic [CNT_W-1:0]      pix_q, pix_d;
  logic [DRAIN_W-1:0]    drain_q, drain_d;
  logic [0:MAX_PIXELS-1] shd_r_q, shd_r_d, shd_g_q, shd_g_d, shd_b_q, shd_b_d;
  logic [0:MAX_PIXELS-1] buf_r_q, buf_r_d, buf_g_q, buf_g_d, buf_b_q, buf_b_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef MIRROR_X_EN
  logic                  mirror_q, mirror_d;
  logic [DIM_W-1:0]      col_q, col_d;
  logic [CNT_W-1:0]      row_base_q, row_base_d;
`endif

  logic [N_W-1:0]   n_full;
  logic             size_ok;
  logic             fetch_vld;
  logic [CNT_W-1:0] fetch_idx;
  logic             pipe_vld;
  logic [CNT_W-1:0] pipe_idx;

  assign n_full  = pixel_count(w_q, h_q);
  assign size_ok = (n_full != '0) && (n_full <= N_W'(MAX_PIXELS));

  // The ROM is read in linear order, so the address and the unflipped
  // index both advance by one per fetch; row_base_q tracks row*W so the
  // flipped index needs no multiplier.
`ifdef MIRROR_X_EN
  assign fetch_idx = mirror_q ? (row_base_q + CNT_W'(w_q - col_q - DIM_W'(1)))
                              : pix_q;
`else
  assign fetch_idx = pix_q;
`endif

  rom_latency_pipe #(
    .LATENCY (ROM_LATENCY),
    .IDX_W   (CNT_W)
  ) u_pipe (
    .clk_i   (CLK),
    .rst_i   (reset),
    .valid_i (fetch_vld),
    .idx_i   (fetch_idx),
    .valid_o (pipe_vld),
    .idx_o   (pipe_idx)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    w_d       = w_q;
    h_d       = h_q;
    n_d       = n_q;
    pix_d     = pix_q;
    drain_d   = drain_q;
    shd_r_d   = shd_r_q;
    shd_g_d   = shd_g_q;
    shd_b_d   = shd_b_q;
    buf_r_d   = buf_r_q;
    buf_g_d   = buf_g_q;
    buf_b_d   = buf_b_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    fetch_vld = 1'b0;
`ifdef MIRROR_X_EN
    mirror_d   = mirror_q;
    col_d      = col_q;
    row_base_d = row_base_q;
`endif

    if (pipe_vld) begin
      shd_r_d[pipe_idx] = ROM_DATA[R_BIT];
      shd_g_d[pipe_idx] = ROM_DATA[G_BIT];
      shd_b_d[pipe_idx] = ROM_DATA[B_BIT];
    end

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_CHECK;
          addr_d  = BASE_ADDR;
          w_d     = LARGURA_OBJETO;
          h_d     = ALTURA_OBJETO;
`ifdef MIRROR_X_EN
          mirror_d = MIRROR_X;
`endif
        end
      end
      ST_CHECK: begin
        if (size_ok) begin
          state_d = ST_FETCH;
          n_d     = CNT_W'(n_full);
          pix_d   = '0;
          shd_r_d = '0;
          shd_g_d = '0;
          shd_b_d = '0;
`ifdef MIRROR_X_EN
          col_d      = '0;
          row_base_d = '0;
`endif
        end else begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end
      end
      ST_FETCH: begin
        fetch_vld = 1'b1;
        addr_d    = addr_q + ADDR_W'(1);
        if (pix_q == n_q - CNT_W'(1)) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_W'(ROM_LATENCY - 1);
        end else begin
          pix_d = pix_q + CNT_W'(1);
        end
`ifdef MIRROR_X_EN
        if (col_q == w_q - DIM_W'(1)) begin
          col_d      = '0;
          row_base_d = row_base_q + CNT_W'(w_q);
        end else begin
          col_d = col_q + DIM_W'(1);
        end
`endif
      end
      ST_DRAIN: begin
        if (drain_q == '0) state_d = ST_READY;
        else               drain_d = drain_q - DRAIN_W'(1);
      end
      ST_READY: begin
        if (FRAME_SYNC) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        buf_r_d = shd_r_q;
        buf_g_d = shd_g_q;
        buf_b_d = shd_b_q;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      w_q     <= '0;
      h_q     <= '0;
      n_q     <= '0;
      pix_q   <= '0;
      drain_q <= '0;
      shd_r_q <= '0;
      shd_g_q <= '0;
      shd_b_q <= '0;
      buf_r_q <= '0;
      buf_g_q <= '0;
      buf_b_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef MIRROR_X_EN
      mirror_q   <= 1'b0;
      col_q      <= '0;
      row_base_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      w_q     <= w_d;
      h_q     <= h_d;
      n_q     <= n_d;
      pix_q   <= pix_d;
      drain_q <= drain_d;
      shd_r_q <= shd_r_d;
      shd_g_q <= shd_g_d;
      shd_b_q <= shd_b_d;
      buf_r_q <= buf_r_d;
      buf_g_q <= buf_g_d;
      buf_b_q <= buf_b_d;
      done_q  <= done_d;
      error_q <= error_d;
`ifdef MIRROR_X_EN
      mirror_q   <= mirror_d;
      col_q      <= col_d;
      row_base_q <= row_base_d;
`endif
    end
  end

  assign ROM_ADDR = addr_q;
  assign BUFFER_R = buf_r_q;
  assign BUFFER_G = buf_g_q;
  assign BUFFER_B = buf_b_q;
  assign BUSY     = (state_q != ST_IDLE);
  assign DONE     = done_q;
  assign ERROR    = error_q;

endmodule

// File: tb/tb_sprite_buffer_loader.sv
// Self-checking bench for sprite_buffer_loader (ROM_LATENCY = 1).
// Build with MIRROR_X_EN defined to include the horizontal-flip case.
module tb_sprite_buffer_loader;

  localparam int LAT = 1;

  typedef struct {
    logic [0:399] r;
    logic [0:399] g;
    logic [0:399] b;
  } exp_t;

  typedef struct {
    int         w;
    int         h;
    logic [11:0] base;
    int         mode;
    bit         mir;
    bit         exp_err;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         fs;
  logic [9:0]   larg;
  logic [9:0]   alt;
  logic [11:0]  base_addr;
  logic [11:0]  rom_addr;
  logic [2:0]   rom_data = 3'b000;
  logic [0:399] buf_r, buf_g, buf_b;
  logic         busy, done, error;
`ifdef MIRROR_X_EN
  logic         mirror_x;
`endif

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          exp_done = 0;
  int          exp_errs = 0;
  exp_t        sb_q[$];
  exp_t        cur;
  exp_t        mon_e;
  int          rom_mode = 0;
  logic [11:0] rom_base = '0;
  vec_t        vecs[10];

  sprite_buffer_loader #(
    .MAX_PIXELS  (400),
    .ADDR_W      (12),
    .ROM_LATENCY (LAT)
  ) dut (
    .CLK            (clk),
    .reset          (rst),
    .START          (start),
    .BASE_ADDR      (base_addr),
    .LARGURA_OBJETO (larg),
    .ALTURA_OBJETO  (alt),
`ifdef MIRROR_X_EN
    .MIRROR_X       (mirror_x),
`endif
    .ROM_ADDR       (rom_addr),
    .ROM_DATA       (rom_data),
    .FRAME_SYNC     (fs),
    .BUFFER_R       (buf_r),
    .BUFFER_G       (buf_g),
    .BUFFER_B       (buf_b),
    .BUSY           (busy),
    .DONE           (done),
    .ERROR          (error)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] rom_fn(input logic [11:0] a, input int mode,
                                        input logic [11:0] base);
    case (mode)
      0:       return {a[0], a[1], a[2]};
      1:       return 3'b111;
      2:       return (a == base) ? 3'b111 : 3'b000;
      default: return 3'b000;
    endcase
  endfunction

  // One-cycle synchronous sprite ROM.
  always @(posedge clk) rom_data <= rom_fn(rom_addr, rom_mode, rom_base);

  function automatic exp_t model(input int w, input int h, input logic [11:0] base,
                                 input int mode, input bit mir);
    exp_t e;
    e.r = '0;
    e.g = '0;
    e.b = '0;
    for (int i = 0; i < w * h; i++) begin
      logic [11:0] a;
      logic [2:0]  p;
      int          c;
      int          idx;
      a   = base + 12'(i);
      p   = rom_fn(a, mode, base);
      c   = i % w;
      idx = mir ? (i - c + (w - 1 - c)) : i;
      e.r[idx] = p[2];
      e.g[idx] = p[1];
      e.b[idx] = p[0];
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic chk_buf(input string name, input logic [0:399] act, input logic [0:399] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Scoreboard side: every DONE must match the oldest queued load.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected act=1 exp=0");
      end else begin
        mon_e = sb_q.pop_front();
        chk_buf("sb_buf_r", buf_r, mon_e.r);
        chk_buf("sb_buf_g", buf_g, mon_e.g);
        chk_buf("sb_buf_b", buf_b, mon_e.b);
        cur = mon_e;
      end
    end
    if (error) err_cnt++;
  end

  task automatic drive_start(input int w, input int h, input logic [11:0] base,
                             input int mode, input bit mir);
    rom_mode  = mode;
    rom_base  = base;
    start     = 1'b1;
    larg      = 10'(w);
    alt       = 10'(h);
    base_addr = base;
`ifdef MIRROR_X_EN
    mirror_x  = mir;
`else
    if (mir) $display("mirror request ignored in this build");
`endif
  endtask

  task automatic run_load(input int w, input int h, input logic [11:0] base,
                          input int mode, input bit mir, input bit exp_err);
    int n;
    n = w * h;
    drive_start(w, h, base, mode, mir);
    if (!exp_err) sb_q.push_back(model(w, h, base, mode, mir));
    step();                                   // START sampled
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    step();                                   // CHECK resolved
    if (exp_err) begin
      exp_errs++;
      chk("error_pulse", 32'(error), 32'd1);
      chk("error_busy", 32'(busy), 32'd0);
      chk_buf("error_keep_r", buf_r, cur.r);
      chk_buf("error_keep_g", buf_g, cur.g);
      chk_buf("error_keep_b", buf_b, cur.b);
      step();
      chk("error_one_cycle", 32'(error), 32'd0);
    end else begin
      chk("no_error", 32'(error), 32'd0);
      repeat (n + LAT) step();                // now in READY
      fs = 1'b1;
      step();
      fs = 1'b0;
      chk("commit_busy", 32'(busy), 32'd1);
      chk("commit_no_done", 32'(done), 32'd0);
      step();
      exp_done++;
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      step();
      chk("done_one_cycle", 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [0:11] r12;
    logic [0:3]  r4;

    vecs[0] = '{20,   21,   12'h000, 0, 1'b0, 1'b1};
    vecs[1] = '{20,   20,   12'h100, 0, 1'b0, 1'b0};
    vecs[2] = '{2,    2,    12'h200, 1, 1'b0, 1'b0};
    vecs[3] = '{0,    5,    12'h000, 0, 1'b0, 1'b1};
    vecs[4] = '{10,   0,    12'h000, 0, 1'b0, 1'b1};
    vecs[5] = '{401,  1,    12'h000, 0, 1'b0, 1'b1};
    vecs[6] = '{1023, 1023, 12'h000, 0, 1'b0, 1'b1};
    vecs[7] = '{400,  1,    12'hFF0, 0, 1'b0, 1'b0};
    vecs[8] = '{1,    400,  12'h7C5, 0, 1'b0, 1'b0};
    vecs[9] = '{1,    1,    12'h123, 1, 1'b0, 1'b0};

    cur.r = '0; cur.g = '0; cur.b = '0;
    rst = 1'b1; start = 1'b0; fs = 1'b0;
    larg = '0; alt = '0; base_addr = '0;
`ifdef MIRROR_X_EN
    mirror_x = 1'b0;
`endif
    repeat (3) step();
    chk_buf("reset_buf_r", buf_r, '0);
    chk_buf("reset_buf_g", buf_g, '0);
    chk_buf("reset_buf_b", buf_b, '0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    chk("reset_rom_addr", 32'(rom_addr), 32'd0);
    rst = 1'b0;
    step();

    // 4x3 at 0x010: address sweep, FRAME_SYNC + START noise during FETCH,
    // a FRAME_SYNC in DRAIN that must be ignored, then commit from READY.
    drive_start(4, 3, 12'h010, 0, 1'b0);
    sb_q.push_back(model(4, 3, 12'h010, 0, 1'b0));
    step();
    start = 1'b0;
    step();
    for (int k = 0; k < 12; k++) begin
      chk("fetch_rom_addr", 32'(rom_addr), 32'h010 + 32'(k));
      if (k == 3) begin
        start = 1'b1; larg = 10'd1; alt = 10'd1; fs = 1'b1;
      end else if (k == 4) begin
        start = 1'b0; fs = 1'b0;
      end
      step();
    end
    fs = 1'b1;                                // cycle 13 after START: DRAIN
    step();
    fs = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("ready_wait_busy", 32'(busy), 32'd1);
      chk("ready_wait_no_done", 32'(done), 32'd0);
      if (k < 2) step();
    end
    fs = 1'b1;
    step();
    fs = 1'b0;
    step();
    exp_done++;
    chk("first_done", 32'(done), 32'd1);
    r12 = buf_r[0:11];
    chk("first_buf_r12", 32'(r12), 32'b010101010101);
    step();
    chk("first_done_once", 32'(done), 32'd0);

    for (int i = 0; i < 10; i++)
      run_load(vecs[i].w, vecs[i].h, vecs[i].base, vecs[i].mode, vecs[i].mir,
               vecs[i].exp_err);

    // Reset in the middle of a 10x10 fetch.
    drive_start(10, 10, 12'h300, 0, 1'b0);
    step();
    start = 1'b0;
    repeat (20) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cur.r = '0; cur.g = '0; cur.b = '0;
    chk_buf("midreset_buf_r", buf_r, '0);
    chk_buf("midreset_buf_g", buf_g, '0);
    chk_buf("midreset_buf_b", buf_b, '0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    repeat (120) step();
    chk("midreset_stays_idle", 32'(busy), 32'd0);

`ifdef MIRROR_X_EN
    run_load(4, 1, 12'h040, 2, 1'b1, 1'b0);
    r4 = buf_r[0:3];
    chk("mirror_buf_r4", 32'(r4), 32'b0001);
`else
    run_load(4, 1, 12'h040, 2, 1'b0, 1'b0);
    r4 = buf_r[0:3];
    chk("plain_buf_r4", 32'(r4), 32'b1000);
`endif

    repeat (3) step();
    chk("sb_queue_empty", 32'(sb_q.size()), 32'd0);
    chk("done_count", 32'(done_cnt), 32'(exp_done));
    chk("error_count", 32'(err_cnt), 32'(exp_errs));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
